matrix_conv_engine: RTL

//  Parametrised successor of the fixed 3x3-in/2x2-out matrix convolution block.
//  - Convolves an IMG_N x IMG_N signed image with a runtime-loadable K x K signed kernel.
//  - Valid mode, stride 1; produces OUT_N x OUT_N results, OUT_N = IMG_N-K+1.
//  - Pixels in and results out are valid/ready streams, so the block sits between a DMA/stream source and a result sink.

---
 rtl/matrix_conv_engine_pkg.sv | 25 ++
 rtl/matrix_conv_engine_if.sv | 26 ++
 rtl/matrix_conv_engine_mac.sv | 36 +++
 rtl/matrix_conv_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_conv_engine_pkg.sv
// Shared types and width helpers for the matrix convolution engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package matrix_conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        EMIT,
        DONE
    } state_t;

    // Full-precision accumulator width: a DATA_W x DATA_W product needs
    // 2*DATA_W bits, and summing K*K of them adds clog2(K*K) more.
    function automatic int acc_width(input int data_w, input int k);
        return 2 * data_w + $clog2(k * k);
    endfunction

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_conv_engine_if.sv
// Pixel-in / result-out stream pair between a source, the engine and a sink.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams; a beat moves when valid & ready.
//   master : stream source / result sink (drives in_valid, in_data, out_ready)
//   slave  : the engine (drives in_ready, out_valid, out_data)
interface matrix_conv_engine_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 66
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/matrix_conv_engine_mac.sv
// Signed multiply-accumulate: acc <= (clr ? 0 : acc) + a*b when en.
// Latency: 1 cycle from operands to updated acc.
// Backpressure: none; the caller sequences clr/en.
//   clk, reset (async, active low), clr, en, a, b -> acc
module conv_mac_unit #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 66
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    // Operands are widened (sign-extended) before multiplying so the full
    // double-width product is kept, then sign-extended to the accumulator.
    assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    assign prod_ext = ACC_W'(prod);

    // clr together with en loads the first product directly, so the first
    // tap of a window needs no separate clearing cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= en ? prod_ext : '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end
endmodule

// File: rtl/matrix_conv_engine.sv
// Valid-mode stride-1 convolution of an IMG_N x IMG_N image with a K x K kernel.
// Latency: first result K*K+1 cycles after the last pixel accept, then K*K+1 per result.
// Backpressure: in_ready only in LOAD; each result holds on out_data until out_ready.
//   clk, reset (async, active low)
//   start/relu_en : frame launch (IDLE only), relu_en captured with start
//   k_we/k_addr/k_data : kernel coefficient write (IDLE only), row-major
//   bus (slave)   : pixel stream in, result stream out, both row-major
//   busy : not IDLE;  done : one cycle after the last result is accepted
module matrix_conv_engine
    import matrix_conv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMG_N  = 3,
    parameter int K      = 2,
    parameter int ACC_W  = acc_width(DATA_W, K),
    localparam int KA_W  = idx_width(K * K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              relu_en,
    input  logic              k_we,
    input  logic [KA_W-1:0]   k_addr,
    input  logic [DATA_W-1:0] k_data,
    matrix_conv_engine_if.slave bus,
    output logic              busy,
    output logic              done
);
    localparam int OUT_N = IMG_N - K + 1;
    localparam int NPIX  = IMG_N * IMG_N;
    localparam int PIX_W = idx_width(NPIX);
    localparam int RC_W  = idx_width(OUT_N);
    localparam int IJ_W  = idx_width(K);

    state_t state_q, state_d;

    logic [PIX_W-1:0] pix_cnt_q;
    logic [RC_W-1:0]  r_q, c_q;
    logic [IJ_W-1:0]  i_q, j_q;
    logic             relu_q;

    // Storage only; contents survive reset so a kernel can be reused.
    logic signed [DATA_W-1:0] kern_mem  [K*K];
    logic signed [DATA_W-1:0] frame_mem [NPIX];

    logic                     in_ready_c, out_valid_c;
    logic                     mac_en, mac_clr;
    logic [PIX_W-1:0]         pix_sel;
    logic [KA_W-1:0]          coef_sel;
    logic signed [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]         result;

    logic last_pix, last_tap, last_out, last_col;

    assign last_pix = (pix_cnt_q == PIX_W'(NPIX - 1));
    assign last_tap = (i_q == IJ_W'(K - 1)) && (j_q == IJ_W'(K - 1));
    assign last_col = (c_q == RC_W'(OUT_N - 1));
    assign last_out = (r_q == RC_W'(OUT_N - 1)) && last_col;

    // Current tap: image pixel (r+i, c+j) against coefficient (i, j).
    assign pix_sel  = PIX_W'((int'(r_q) + int'(i_q)) * IMG_N + int'(c_q) + int'(j_q));
    assign coef_sel = KA_W'(int'(i_q) * K + int'(j_q));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_pix) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (i_q == '0) && (j_q == '0);
                if (last_tap) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = last_out ? DONE : MAC;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q <= '0;
            r_q       <= '0;
            c_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            relu_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        relu_q    <= relu_en;
                        pix_cnt_q <= '0;
                        r_q       <= '0;
                        c_q       <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        pix_cnt_q <= last_pix ? '0 : pix_cnt_q + PIX_W'(1);
                    end
                end
                MAC: begin
                    // Kernel walked row-major; both indices end back at 0.
                    if (j_q == IJ_W'(K - 1)) begin
                        j_q <= '0;
                        i_q <= (i_q == IJ_W'(K - 1)) ? '0 : i_q + IJ_W'(1);
                    end else begin
                        j_q <= j_q + IJ_W'(1);
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last_out) begin
                            r_q <= '0;
                            c_q <= '0;
                        end else if (last_col) begin
                            c_q <= '0;
                            r_q <= r_q + RC_W'(1);
                        end else begin
                            c_q <= c_q + RC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- storage
    // The range guard drops writes to addresses past K*K when K*K is not
    // a power of two.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && k_we && (int'(k_addr) < K * K)) begin
            kern_mem[k_addr] <= k_data;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == LOAD) && bus.in_valid) begin
            frame_mem[pix_cnt_q] <= bus.in_data;
        end
    end

    // ----------------------------------------------------------------- MAC
    conv_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (frame_mem[pix_sel]),
        .b     (kern_mem[coef_sel]),
        .acc   (acc)
    );

    // acc is frozen during EMIT, so the result holds until it is taken.
    assign result        = (relu_q && acc[ACC_W-1]) ? '0 : acc;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_valid_c ? result : '0;

endmodule
